// File: rtl/stream_framer_pkg.sv
// stream_framer_pkg: shared state encoding and frame-counter width for the stream framer
package stream_framer_pkg;
    typedef enum logic {ST_DATA, ST_CSUM} framer_state_t;
    localparam int FRAMES_W = 16;
endpackage

// File: rtl/stream_framer_fifo.sv
// stream_framer_fifo: circular word buffer with combinational head read
//   clk, rst (async active-low) | push/wdata write at tail | pop advances head
//   rdata = head entry | empty, full, count = occupancy flags and level
module stream_framer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/stream_framer.sv
// stream_framer: buffers an unthrottled word stream and emits FRAME_LEN-word frames plus a checksum word
//   clk, rst (async active-low)
//   i_data/i_valid: upstream words, no backpressure
//   o_data/o_valid/i_ready: ready/valid output toward the sink; o_last marks the checksum word
//   o_overflow: sticky drop flag | o_frames: completed frame count (wraps)
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int DEPTH     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    i_data,
    input  logic                i_valid,
    output logic [WIDTH-1:0]    o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_overflow,
    output logic [FRAMES_W-1:0] o_frames
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(FRAME_LEN + 1);

    framer_state_t    state, state_nxt;
    logic [WIDTH-1:0] sum, head;
    logic [NW-1:0]    cnt;
    logic [CW-1:0]    fifo_count;
    logic             empty, full, push, pop, xfer;

    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push = i_valid && (!full || pop);

    stream_framer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(i_data),
        .rdata(head),
        .empty(empty),
        .full (full),
        .count(fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_DATA;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_last    = state == ST_CSUM;
        o_valid   = o_last || !empty;
        o_data    = o_last ? sum : (empty ? '0 : head);
        xfer      = o_valid && i_ready;
        pop       = xfer && !o_last;
        if (xfer) state_nxt = o_last ? ST_DATA : (cnt == NW'(FRAME_LEN - 1) ? ST_CSUM : ST_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum        <= '0;
            cnt        <= '0;
            o_frames   <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (i_valid && !push) o_overflow <= 1'b1;
            if (xfer && o_last) begin
                sum      <= '0;
                cnt      <= '0;
                o_frames <= o_frames + 1'b1;
            end else if (xfer) begin
                sum <= sum + o_data;
                cnt <= cnt + 1'b1;
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) fifo_count <= CW'(DEPTH));
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: directed and random checks of stream_framer against a queue-based frame model
module tb_stream_framer;
    localparam int WIDTH = 8, FRAME_LEN = 4, DEPTH = 8;

    logic             clk = 0, rst = 0, i_valid = 0, i_ready = 0;
    logic [WIDTH-1:0] i_data = '0;
    logic [WIDTH-1:0] o_data;
    logic             o_valid, o_last, o_overflow;
    logic [15:0]      o_frames;

    stream_framer #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_overflow(o_overflow), .o_frames(o_frames)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    logic [WIDTH-1:0] q[$];
    bit               m_csum, m_ovf;
    int               m_cnt;
    logic [WIDTH-1:0] m_sum, last_csum;
    logic [15:0]      m_frames;
    bit               prev_hold;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_csum = 0; m_ovf = 0; m_cnt = 0; m_sum = '0; m_frames = '0; prev_hold = 0;
    endtask

    // async reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        rst = 0; i_valid = 0; i_ready = 0;
        #1;
        model_clear();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_last", o_last, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_frames", o_frames, 0);
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r);
        logic             e_valid, e_last;
        logic [WIDTH-1:0] e_data;
        bit               xfer;
        i_valid = v; i_data = d; i_ready = r;
        #1;
        e_valid = m_csum || q.size() > 0;
        e_last  = m_csum;
        e_data  = m_csum ? m_sum : (q.size() > 0 ? q[0] : '0);
        check("valid", o_valid, e_valid);
        check("data", o_data, e_data);
        check("last", o_last, e_last);
        check("ovf", o_overflow, m_ovf);
        check("frames", o_frames, m_frames);
        if (prev_hold) begin
            check("hold_data", o_data, prev_data);
            check("hold_last", o_last, prev_last);
        end
        prev_hold = o_valid && !r;
        prev_data = o_data;
        prev_last = o_last;
        if (o_valid && o_last && r) last_csum = o_data;
        xfer = e_valid && r;
        if (xfer && m_csum) begin
            m_csum = 0; m_sum = '0; m_cnt = 0; m_frames++;
        end else if (xfer) begin
            m_sum += q.pop_front();
            m_cnt++;
            if (m_cnt == FRAME_LEN) m_csum = 1;
        end
        if (v) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 1);
    endtask

    initial begin
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 1);
        idle(3);
        check("t1_csum", last_csum, 8'h0A);
        check("t1_frames", o_frames, 1);
        check("t1_ovf", o_overflow, 0);

        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, WIDTH'($urandom), 0);
        check("t2_ovf_full", o_overflow, 0);
        cycle(1, 8'hEE, 0);
        check("t2_ovf_drop", o_overflow, 1);
        idle(12);
        check("t2_frames", o_frames, 2);

        do_reset();
        cycle(1, 8'hFF, 1); cycle(1, 8'h02, 1); cycle(1, 8'h00, 1); cycle(1, 8'h00, 1);
        idle(3);
        check("t3_csum", last_csum, 8'h01);

        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, WIDTH'($urandom), 0);
        cycle(1, 8'h5A, 1);
        check("t4_ovf", o_overflow, 0);
        idle(12);
        check("t4_frames", o_frames, 2);

        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, WIDTH'($urandom), 1);
        cycle(0, '0, 1);
        check("t5_in_csum", o_last, 1);
        for (int i = 0; i < 3; i++) cycle(1, WIDTH'($urandom), 0);
        cycle(1, WIDTH'($urandom), 1);
        idle(6);
        check("t5_frames", o_frames, 2);

        do_reset();
        cycle(1, 8'h11, 1); cycle(1, 8'h22, 1);
        cycle(0, '0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 8'h05, 1);
        idle(3);
        check("t6_csum", last_csum, 8'h14);
        check("t6_frames", o_frames, 1);

        do_reset();
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) != 0);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
